// File: rtl/mem_access_ctrl.sv
// Purpose     : DLX memory-stage load/store sequencer in front of a word RAM (async read, sync write).
// Latency     : ACK one cycle after accept on a fault, two for loads and word stores, three for byte/half stores.
// Backpressure: one request in flight; REQ is ignored while BUSY is high and nothing is queued.
//
// Ports:
//   CLK, RST                              clock, synchronous active-high reset
//   REQ, RW, SIZE, SIGNED, ADDR_IN, WDATA  request, latched at the accept edge in IDLE
//   RDATA, ACK, FAULT, BUSY               registered load result, completion pulse and status
//   MEM_ADDR, MEM_WE, MEM_DI, MEM_DO      word RAM port (MEM_DO is combinational from MEM_ADDR)
module mem_access_ctrl #(
    parameter int AW = 5
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          REQ,
    input  logic          RW,
    input  logic [1:0]    SIZE,
    input  logic          SIGNED,
    input  logic [AW+1:0] ADDR_IN,
    input  logic [31:0]   WDATA,
    output logic [31:0]   RDATA,
    output logic          ACK,
    output logic          FAULT,
    output logic          BUSY,
    output logic [AW-1:0] MEM_ADDR,
    output logic          MEM_WE,
    output logic [31:0]   MEM_DI,
    input  logic [31:0]   MEM_DO
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RD     = 3'd1,
        S_RMW_RD = 3'd2,
        S_WR     = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    state_t        state;

    // Request captured at the accept edge.
    logic          rw_q;
    logic [1:0]    size_q;
    logic          signed_q;
    logic [AW+1:0] addr_q;
    logic [31:0]   wdata_q;

    // Alignment / size check on the incoming request.
    logic          req_fault;

    always_comb begin
        req_fault = 1'b0;
        case (SIZE)
            SZ_BYTE: req_fault = 1'b0;
            SZ_HALF: req_fault = ADDR_IN[0];
            SZ_WORD: req_fault = |ADDR_IN[1:0];
            default: req_fault = 1'b1;
        endcase
    end

    // Load path: pick the big-endian lane out of the RAM word and extend it.
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_val;

    always_comb begin
        ld_byte = 8'h00;
        case (addr_q[1:0])
            2'd0:    ld_byte = MEM_DO[31:24];
            2'd1:    ld_byte = MEM_DO[23:16];
            2'd2:    ld_byte = MEM_DO[15:8];
            default: ld_byte = MEM_DO[7:0];
        endcase

        ld_half = addr_q[1] ? MEM_DO[15:0] : MEM_DO[31:16];

        ld_val = MEM_DO;
        case (size_q)
            SZ_BYTE: ld_val = {{24{signed_q & ld_byte[7]}}, ld_byte};
            SZ_HALF: ld_val = {{16{signed_q & ld_half[15]}}, ld_half};
            default: ld_val = MEM_DO;
        endcase
    end

    // Store path: overlay the addressed lane of the old word with WDATA's low bits.
    logic [31:0] merged;

    always_comb begin
        merged = MEM_DO;
        if (size_q == SZ_BYTE) begin
            case (addr_q[1:0])
                2'd0:    merged[31:24] = wdata_q[7:0];
                2'd1:    merged[23:16] = wdata_q[7:0];
                2'd2:    merged[15:8]  = wdata_q[7:0];
                default: merged[7:0]   = wdata_q[7:0];
            endcase
        end else if (addr_q[1]) begin
            merged[15:0] = wdata_q[15:0];
        end else begin
            merged[31:16] = wdata_q[15:0];
        end
    end

    // Decoded from the registered state so the RAM sees a clean enable for the
    // whole WR cycle; RST gates it so a reset landing in WR drops the write.
    // rw_q is always 1 in WR; it keeps a corrupted state from ever writing on a load.
    assign MEM_WE = (state == S_WR) && rw_q && !RST;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= S_IDLE;
            rw_q     <= 1'b0;
            size_q   <= 2'b00;
            signed_q <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= 32'h0;
            RDATA    <= 32'h0;
            ACK      <= 1'b0;
            FAULT    <= 1'b0;
            BUSY     <= 1'b0;
            MEM_ADDR <= '0;
            MEM_DI   <= 32'h0;
        end else begin
            case (state)
                S_IDLE: begin
                    ACK   <= 1'b0;
                    FAULT <= 1'b0;
                    if (REQ) begin
                        rw_q     <= RW;
                        size_q   <= SIZE;
                        signed_q <= SIGNED;
                        addr_q   <= ADDR_IN;
                        wdata_q  <= WDATA;
                        // Drive the word address now so the async RAM read is
                        // already valid during the first busy cycle.
                        MEM_ADDR <= ADDR_IN[AW+1:2];
                        BUSY     <= 1'b1;
                        if (req_fault) begin
                            state <= S_DONE;
                            ACK   <= 1'b1;
                            FAULT <= 1'b1;
                        end else if (!RW) begin
                            state <= S_RD;
                        end else if (SIZE == SZ_WORD) begin
                            state  <= S_WR;
                            MEM_DI <= WDATA;
                        end else begin
                            state <= S_RMW_RD;
                        end
                    end
                end

                S_RD: begin
                    RDATA <= ld_val;
                    ACK   <= 1'b1;
                    state <= S_DONE;
                end

                S_RMW_RD: begin
                    // MEM_DI doubles as the merge register for the write cycle.
                    MEM_DI <= merged;
                    state  <= S_WR;
                end

                S_WR: begin
                    ACK   <= 1'b1;
                    state <= S_DONE;
                end

                S_DONE: begin
                    ACK   <= 1'b0;
                    FAULT <= 1'b0;
                    BUSY  <= 1'b0;
                    state <= S_IDLE;
                end

                default: begin
                    ACK   <= 1'b0;
                    FAULT <= 1'b0;
                    BUSY  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Purpose     : self-checking bench for mem_access_ctrl with a word RAM and a transaction-level reference model.
// Latency     : n/a (bench).
// Backpressure: n/a (bench); one request at a time, waiting for ACK with a bounded cycle budget.
module tb_mem_access_ctrl;

    localparam int AW = 5;

    logic          CLK = 1'b0;
    logic          RST;
    logic          REQ;
    logic          RW;
    logic [1:0]    SIZE;
    logic          SIGNED;
    logic [AW+1:0] ADDR_IN;
    logic [31:0]   WDATA;
    logic [31:0]   RDATA;
    logic          ACK;
    logic          FAULT;
    logic          BUSY;
    logic [AW-1:0] MEM_ADDR;
    logic          MEM_WE;
    logic [31:0]   MEM_DI;
    logic [31:0]   MEM_DO;

    mem_access_ctrl #(.AW(AW)) dut (
        .CLK     (CLK),
        .RST     (RST),
        .REQ     (REQ),
        .RW      (RW),
        .SIZE    (SIZE),
        .SIGNED  (SIGNED),
        .ADDR_IN (ADDR_IN),
        .WDATA   (WDATA),
        .RDATA   (RDATA),
        .ACK     (ACK),
        .FAULT   (FAULT),
        .BUSY    (BUSY),
        .MEM_ADDR(MEM_ADDR),
        .MEM_WE  (MEM_WE),
        .MEM_DI  (MEM_DI),
        .MEM_DO  (MEM_DO)
    );

    always #5 CLK = ~CLK;

    // Word RAM: async read, write at posedge.
    logic [31:0] ram [32];
    assign MEM_DO = ram[MEM_ADDR];
    always @(posedge CLK) begin
        if (MEM_WE) ram[MEM_ADDR] <= MEM_DI;
    end

    // Reference model state.
    logic [31:0] ref_mem [32];
    logic [31:0] ref_rdata;

    int err_cnt = 0;
    int chk_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic bit is_fault(input logic [1:0] sz, input logic [6:0] a);
        return (sz == 2'd3) || (sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0);
    endfunction

    // Cycles from the accept edge to the first cycle with ACK high.
    function automatic int exp_latency(input bit rw, input logic [1:0] sz, input logic [6:0] a);
        if (is_fault(sz, a)) return 1;
        if (!rw) return 2;
        if (sz == 2'd2) return 2;
        return 3;
    endfunction

    // Big-endian lane position: byte k sits 8*(3-k) bits up, half 0 sits 16 up.
    function automatic int lane_shift(input logic [1:0] sz, input logic [6:0] a);
        if (sz == 2'd0) return (3 - int'(a % 4)) * 8;
        return (a % 4 == 0) ? 16 : 0;
    endfunction

    function automatic logic [31:0] model_load(input logic [1:0] sz, input bit sgn, input logic [6:0] a);
        logic [31:0] word;
        logic [31:0] mask;
        logic [31:0] v;
        word = ref_mem[a / 4];
        if (sz == 2'd2) return word;
        mask = (sz == 2'd0) ? 32'h0000_00FF : 32'h0000_FFFF;
        v = (word >> lane_shift(sz, a)) & mask;
        if (sgn && ((v & ((mask >> 1) + 1)) != 0)) v = v | ~mask;
        return v;
    endfunction

    function automatic void model_store(input logic [1:0] sz, input logic [6:0] a, input logic [31:0] wd);
        logic [31:0] mask;
        int sh;
        if (sz == 2'd2) begin
            ref_mem[a / 4] = wd;
        end else begin
            mask = (sz == 2'd0) ? 32'h0000_00FF : 32'h0000_FFFF;
            sh = lane_shift(sz, a);
            ref_mem[a / 4] = (ref_mem[a / 4] & ~(mask << sh)) | ((wd & mask) << sh);
        end
    endfunction

    // One full transaction; poke pulses a second REQ during the first busy cycle.
    task automatic do_req(input bit rw, input logic [1:0] sz, input bit sgn,
                          input logic [6:0] a, input logic [31:0] wd, input bit poke);
        int  n;
        int  we_cnt;
        bit  got_ack;
        bit  f;
        f = is_fault(sz, a);
        @(negedge CLK);
        REQ = 1'b1; RW = rw; SIZE = sz; SIGNED = sgn; ADDR_IN = a; WDATA = wd;
        @(negedge CLK);
        REQ = 1'b0;
        n = 1; we_cnt = 0; got_ack = 1'b0;
        while (n <= 8) begin
            if (MEM_WE) we_cnt++;
            if (BUSY) check("mem_addr", 32'(MEM_ADDR), 32'(a / 4));
            if (ACK) begin
                got_ack = 1'b1;
                break;
            end
            check("busy_inflight", 32'(BUSY), 32'd1);
            if (poke && n == 1) begin
                REQ = 1'b1; RW = 1'b0; SIZE = 2'd2; SIGNED = 1'b0; ADDR_IN = 7'h00;
            end
            if (poke && n == 2) REQ = 1'b0;
            @(negedge CLK);
            n++;
        end
        check("ack_seen", 32'(got_ack), 32'd1);
        check("latency", 32'(n), 32'(exp_latency(rw, sz, a)));
        check("fault", 32'(FAULT), 32'(f));
        check("we_cycles", 32'(we_cnt), (!f && rw) ? 32'd1 : 32'd0);
        if (!f && !rw) ref_rdata = model_load(sz, sgn, a);
        if (!f && rw)  model_store(sz, a, wd);
        check("rdata", RDATA, ref_rdata);
        @(negedge CLK);
        check("ack_drop", 32'(ACK), 32'd0);
        check("fault_drop", 32'(FAULT), 32'd0);
        check("busy_drop", 32'(BUSY), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] old;
        RST = 1'b1; REQ = 1'b0; RW = 1'b0; SIZE = 2'd0; SIGNED = 1'b0;
        ADDR_IN = '0; WDATA = 32'h0;
        ref_rdata = 32'h0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;

        // Reset state.
        check("rst_rdata", RDATA, 32'h0);
        check("rst_ack", 32'(ACK), 32'd0);
        check("rst_fault", 32'(FAULT), 32'd0);
        check("rst_busy", 32'(BUSY), 32'd0);
        check("rst_mem_addr", 32'(MEM_ADDR), 32'd0);
        check("rst_mem_we", 32'(MEM_WE), 32'd0);
        check("rst_mem_di", MEM_DI, 32'h0);

        // Fill every RAM word through the DUT so model and RAM agree.
        for (int i = 0; i < 32; i++) do_req(1'b1, 2'd2, 1'b0, 7'(i * 4), $urandom, 1'b0);

        // Word store then word load.
        do_req(1'b1, 2'd2, 1'b0, 7'h10, 32'hDEADBEEF, 1'b0);
        do_req(1'b0, 2'd2, 1'b0, 7'h10, 32'h0, 1'b0);
        check("tp_word_load", RDATA, 32'hDEADBEEF);

        // Byte read-modify-write.
        do_req(1'b1, 2'd0, 1'b0, 7'h12, 32'h00000055, 1'b0);
        check("tp_byte_rmw", ram[4], 32'hDEAD55EF);

        // Sign / zero extension.
        do_req(1'b0, 2'd0, 1'b1, 7'h10, 32'h0, 1'b0);
        check("tp_sbyte", RDATA, 32'hFFFFFFDE);
        do_req(1'b0, 2'd0, 1'b0, 7'h10, 32'h0, 1'b0);
        check("tp_ubyte", RDATA, 32'h000000DE);
        do_req(1'b0, 2'd1, 1'b1, 7'h12, 32'h0, 1'b0);
        check("tp_shalf", RDATA, 32'h000055EF);

        // Alignment and illegal-size faults.
        do_req(1'b0, 2'd1, 1'b0, 7'h11, 32'h0, 1'b0);
        do_req(1'b1, 2'd2, 1'b0, 7'h13, 32'hCAFEF00D, 1'b0);
        do_req(1'b0, 2'd3, 1'b0, 7'h10, 32'h0, 1'b0);
        check("tp_fault_ram", ram[4], 32'hDEAD55EF);

        // Second REQ during a sub-word store must be ignored.
        do_req(1'b1, 2'd1, 1'b0, 7'h14, 32'h0000A5A5, 1'b1);
        for (int i = 0; i < 3; i++) begin
            check("ignored_no_ack", 32'(ACK), 32'd0);
            check("ignored_idle", 32'(BUSY), 32'd0);
            @(negedge CLK);
        end
        do_req(1'b0, 2'd2, 1'b0, 7'h14, 32'h0, 1'b0);

        // Reset during the WR cycle of a word store.
        old = ref_mem[2];
        @(negedge CLK);
        REQ = 1'b1; RW = 1'b1; SIZE = 2'd2; SIGNED = 1'b0; ADDR_IN = 7'h08; WDATA = 32'h12345678;
        @(negedge CLK);
        REQ = 1'b0;
        check("wr_busy", 32'(BUSY), 32'd1);
        RST = 1'b1;
        #1;
        check("wr_we_gated", 32'(MEM_WE), 32'd0);
        @(negedge CLK);
        RST = 1'b0;
        ref_rdata = 32'h0;
        check("wr_rst_ack", 32'(ACK), 32'd0);
        check("wr_rst_busy", 32'(BUSY), 32'd0);
        check("wr_rst_rdata", RDATA, ref_rdata);
        check("wr_rst_ram", ram[2], old);
        do_req(1'b0, 2'd2, 1'b0, 7'h08, 32'h0, 1'b0);
        check("wr_rst_reload", RDATA, old);

        // Randomized traffic against the model.
        for (int i = 0; i < 200; i++) begin
            do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   7'($urandom_range(0, 127)), $urandom, 1'b0);
        end

        // Final RAM contents against the model.
        for (int i = 0; i < 32; i++) check("final_ram", ram[i], ref_mem[i]);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Load/store sequencer between the DLX datapath memory stage and the 32x32 word data RAM (async read, sync write on CLK).
- Accepts byte/halfword/word requests on a byte address and enforces alignment.
- Sub-word stores are done as a read-modify-write on the word RAM.
- Loads are returned lane-extracted and sign- or zero-extended, in big-endian byte order.

Parameters:
- AW, 5, word-address width; RAM depth is 2^AW words; byte address is AW+2 bits.

Ports:
- CLK  in  1  system clock; all state updates on posedge.
- RST  in  1  synchronous, active-high reset.
- REQ  in  1  request valid; sampled only when BUSY=0.
- RW  in  1  1=store, 0=load.
- SIZE  in  2  00 byte, 01 half, 10 word, 11 illegal.
- SIGNED  in  1  loads only: 1=sign-extend, 0=zero-extend.
- ADDR_IN  in  AW+2  byte address.
- WDATA  in  32  store data, right-justified (byte in [7:0], half in [15:0]).
- RDATA  out  32  registered load result.
- ACK  out  1  one-cycle completion pulse.
- FAULT  out  1  valid with ACK; 1 = request rejected, no RAM write.
- BUSY  out  1  high in every state except IDLE.
- MEM_ADDR  out  AW  RAM word address.
- MEM_WE  out  1  RAM write enable.
- MEM_DI  out  32  RAM write data.
- MEM_DO  in  32  RAM read data (combinational from MEM_ADDR).

Behaviour:
- Clock/reset: one clock, CLK; reset RST is synchronous and active-high.
- Reset values: state IDLE; RDATA=0, ACK=0, FAULT=0, BUSY=0, MEM_ADDR=0, MEM_WE=0, MEM_DI=0; all latched request registers 0.
- Accept: a request is accepted at the posedge where state=IDLE and REQ=1. At that edge, latch RW, SIZE, SIGNED, ADDR_IN and WDATA. REQ is ignored while BUSY=1; there is no queueing.
- Fault: a request faults if SIZE=11, or SIZE=01 with ADDR_IN[0]=1, or SIZE=10 with ADDR_IN[1:0]!=00.
- FSM states: IDLE, RD, RMW_RD, WR, DONE.
  - IDLE: on accept, go to DONE (fault), RD (load), WR (word store) or RMW_RD (byte/half store).
  - RD: capture the extracted/extended MEM_DO into RDATA, then go to DONE.
  - RMW_RD: capture MEM_DO into the merge register, replace the addressed lane with WDATA's low bits, then go to WR.
  - WR: MEM_WE=1, MEM_DI=merged word (or WDATA for a word store); the RAM writes at the end of this cycle. Then go to DONE.
  - DONE: ACK=1 for exactly one cycle, FAULT = latched fault flag; then go to IDLE. FAULT returns to 0 when ACK drops.
- MEM_ADDR: equals the latched byte address bits [AW+1:2] whenever BUSY=1, and holds its last value in IDLE.
- MEM_WE: registered-state decode, (state==WR) AND NOT RST. A reset asserted during WR suppresses the write.
- Lane map (big-endian):
  - Byte offset 0 → [31:24], 1 → [23:16], 2 → [15:8], 3 → [7:0].
  - Half offset 0 → [31:16], 2 → [15:0].
- Load extension: SIGNED=1 replicates the lane MSB into the upper bits; SIGNED=0 fills them with 0.
- RDATA update rule: RDATA changes only in RD. Stores and faults leave RDATA unchanged.
- Latency (accept edge = E0; ACK high in the cycle after the listed edge):
  - Fault: after E0.
  - Load: after E1.
  - Word store: after E1, RAM written at E1.
  - Sub-word store: after E2, RAM written at E2.
- Back-to-back: REQ held high during DONE is not accepted. The earliest next accept is the first edge in IDLE, so throughput is one request per latency+1 cycles.
- Reset mid-operation: the state returns to IDLE at the edge where RST=1, and ACK/FAULT are cleared. An in-flight load does not update RDATA. An in-flight store does not write.
- Address wrap: none. Byte address range is 0..(2^(AW+2))-1 and every in-range address is legal subject to alignment.

Test Plan:
- Word store, then load: store 0xDEADBEEF at byte addr 0x10; load word at 0x10 → RDATA=0xDEADBEEF, FAULT=0; ACK 2 cycles after accept; MEM_ADDR=4 during both.
- Byte RMW: with word[4]=0xDEADBEEF, store byte 0x55 at 0x12 → word[4]=0xDEAD55EF; MEM_WE high for exactly one cycle; ACK 3 cycles after accept.
- Sign/zero extension: with word[4]=0xDEAD55EF:
  - Signed byte load at 0x10 → 0xFFFFFFDE.
  - Unsigned byte load at 0x10 → 0x000000DE.
  - Signed half load at 0x12 → 0x000055EF.
- Alignment faults: half at 0x11, word at 0x13, SIZE=11 at 0x10 → each gives ACK=1 with FAULT=1 one cycle after accept; MEM_WE never asserts; RDATA unchanged.
- Busy/ignore: pulse a second REQ while a sub-word store is in RMW_RD → no second ACK and BUSY stays 1; a request presented in IDLE after DONE is accepted normally.
- Reset in WR: assert RST in the WR cycle of a word store of 0x12345678 to 0x08 → word[2] keeps its old value; ACK=0 and BUSY=0 next cycle; a subsequent load at 0x08 returns the old value.
